note_scheduler: RTL

Sequencing controller for the four-lane falling-note game. It owns the game state machine (idle, run, pause, over) and the frame-tick generator that paces note motion. It also picks, each tick, whether and where a new note spawns, using an LFSR plus a round-robin lane arbiter. The datapath consumes its tick/spawn outputs and returns per-lane busy flags plus hit/miss pulses; scores and display logic stay outside.

---
 rtl/game_pkg.sv | 18 +
 rtl/rr_arb4.sv | 29 ++
 rtl/note_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared encodings and widths for the falling-note game sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;
    localparam int SPEED_W   = 3;
    localparam int MAX_LEVEL = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb4.sv
// Round-robin pick of the first free lane starting at ptr.
// Latency: purely combinational.
// Backpressure: none; gnt_valid=0 when every lane is occupied.
module rr_arb4
    import game_pkg::*;
(
    input  logic [NUM_LANES-1:0] free,
    input  logic [LANE_W-1:0]    ptr,
    output logic                 gnt_valid,
    output logic [LANE_W-1:0]    gnt
);

    logic [LANE_W-1:0] idx;

    // Walk offsets from farthest to nearest so the lane closest to ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        idx       = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = ptr + LANE_W'(i);
            if (free[idx]) begin
                gnt_valid = 1'b1;
                gnt       = idx;
            end
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Game FSM, motion-tick pacing and LFSR-driven note spawning for four lanes.
// Latency: tick registered; spawn_valid one cycle after tick; counters update on the edge after a pulse.
// Backpressure: lane_busy masks spawn lanes; no free lane means the spawn is skipped.
module note_scheduler
    import game_pkg::*;
#(
    parameter int          TICK_DIV       = 2500000,
    parameter int          MISS_LIMIT     = 10,
    parameter int          HITS_PER_LEVEL = 10,
    parameter int          SPAWN_THRESH   = 26,
    parameter logic [19:0] LFSR_SEED      = 20'd123456
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 hit,
    input  logic                 miss,
    input  logic [NUM_LANES-1:0] lane_busy,
    output logic                 tick,
    output logic                 spawn_valid,
    output logic [LANE_W-1:0]    spawn_lane,
    output logic [SPEED_W-1:0]   spawn_speed,
    output logic [2:0]           level,
    output logic [1:0]           state,
    output logic [7:0]           miss_cnt
);

    localparam int                CNT_W     = $clog2(TICK_DIV);
    localparam int                HIT_W     = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
    localparam logic [19:0]       SEED      = (LFSR_SEED == 20'd0) ? 20'd1 : LFSR_SEED;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [7:0]        MISS_LAST = 8'(MISS_LIMIT - 1);
    localparam logic [7:0]        THRESH    = 8'(SPAWN_THRESH);
    localparam logic [2:0]        LEVEL_MAX = 3'(MAX_LEVEL);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       tick_cnt;
    logic                   armed;
    logic [HIT_W-1:0]       hit_cnt;
    logic [LANE_W-1:0]      rr_ptr;
    logic [19:0]            lfsr;
    logic                   run_now, game_over, wrap, attempt, spawn_go;
    logic                   gnt_valid;
    logic [LANE_W-1:0]      gnt;
    logic [NUM_LANES-1:0]   lane_free;
    logic [3:0]             speed_sum;
    logic [SPEED_W-1:0]     speed_nxt;

    assign run_now   = (state_q == RUN);
    assign game_over = run_now && miss && (miss_cnt == MISS_LAST);
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN:   if (game_over) state_d = OVER;
                   else if (pause) state_d = PAUSE;
            PAUSE: if (!pause) state_d = RUN;
            OVER:  if (start) state_d = IDLE;
        endcase
    end

    // armed delays counting by one cycle after start, so the first tick period is TICK_DIV+1.
    assign wrap      = run_now && armed && (tick_cnt == CNT_LAST);
    assign attempt   = ({1'b0, lfsr[6:0]} < THRESH);
    assign lane_free = ~lane_busy;
    assign spawn_go  = tick && run_now && (state_d == RUN) && attempt && gnt_valid;
    assign speed_sum = {1'b0, level} + {3'b000, lfsr[8]};
    assign speed_nxt = (speed_sum > 4'(MAX_LEVEL)) ? LEVEL_MAX : speed_sum[2:0];

    rr_arb4 u_arb (
        .free      (lane_free),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr    <= SEED;
        end else begin
            state_q <= state_d;
            lfsr    <= {lfsr[18:0], lfsr[19] ^ lfsr[0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            armed    <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= wrap && (state_d == RUN);
            case (state_q)
                RUN: begin
                    armed <= 1'b1;
                    if (armed)
                        tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
                end
                PAUSE: begin
                end
                default: begin
                    tick_cnt <= '0;
                    armed    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            level    <= 3'd1;
            miss_cnt <= '0;
        end else if (state_q == IDLE && start) begin
            hit_cnt  <= '0;
            level    <= 3'd1;
            miss_cnt <= '0;
        end else if (run_now) begin
            if (hit) begin
                if (hit_cnt == HIT_LAST) begin
                    hit_cnt <= '0;
                    if (level != LEVEL_MAX) level <= level + 3'd1;
                end else begin
                    hit_cnt <= hit_cnt + HIT_W'(1);
                end
            end
            if (miss && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spawn_valid <= 1'b0;
            spawn_lane  <= '0;
            spawn_speed <= '0;
            rr_ptr      <= '0;
        end else begin
            spawn_valid <= spawn_go;
            if (spawn_go) begin
                spawn_lane  <= gnt;
                spawn_speed <= speed_nxt;
                rr_ptr      <= gnt + LANE_W'(1);
            end
        end
    end

endmodule
